// File: rtl/tetris_pkg.sv
// Shared constants for the playfield, the falling-piece mover and the VGA renderer.
//   BLOCK_SIZE            pixel pitch of one board cell
//   COLS / ROWS           board size in cells
//   state_t               playfield processing states
//   SHAPE_MASK[code]      4x4 occupancy mask, bit r*4+c = cell (c, r) of the piece box
//   ANCHOR_OFF[code]      column of the box that sits under the piece anchor
package tetris_pkg;

    localparam int BLOCK_SIZE = 20;
    localparam int COLS       = 24;
    localparam int ROWS       = 24;

    typedef enum logic [2:0] {
        ST_PLAY,
        ST_LOCK,
        ST_SCAN,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Codes 0 and 15 are the square; 1..14 are the tetromino orientations.
    localparam logic [15:0] SHAPE_MASK [0:15] = '{
        16'h0033,  // 0  square
        16'h000F,  // 1  I horizontal
        16'h1111,  // 2  I vertical
        16'h0072,  // 3  T up
        16'h0131,  // 4  T right
        16'h0027,  // 5  T down
        16'h0232,  // 6  T left
        16'h0311,  // 7  L
        16'h0322,  // 8  J
        16'h0036,  // 9  S
        16'h0063,  // 10 Z
        16'h0231,  // 11 S vertical
        16'h0132,  // 12 Z vertical
        16'h0017,  // 13 L flat
        16'h0071,  // 14 J flat
        16'h0033   // 15 square
    };

    localparam logic [1:0] ANCHOR_OFF [0:15] = '{
        2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0,
        2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0
    };

endpackage

// File: rtl/tetris_shape_rom.sv
// Combinational piece lookup.
//   code        in   4   piece code (0 and 15 are the square)
//   mask        out  16  4x4 cell mask, bit r*4+c
//   anchor_off  out  2   box column under the anchor
module tetris_shape_rom
    import tetris_pkg::*;
(
    input  logic [3:0]  code,
    output logic [15:0] mask,
    output logic [1:0]  anchor_off
);

    assign mask       = SHAPE_MASK[code];
    assign anchor_off = ANCHOR_OFF[code];

endmodule

// File: rtl/tetris_playfield.sv
// Settled-block board with collision detection, piece locking, line clearing and score.
//   iVGA_CLK    in   1        clock
//   reset       in   1        synchronous, active-high
//   start_over  in   1        active-low restart, same effect as reset
//   drop_tick   in   1        gravity step pulse
//   ref_x/ref_y in   10       piece anchor in pixels
//   shape       in   32       piece code in the low 4 bits
//   stop        out  1        piece committed, board busy
//   hit         out  1        live piece horizontally touches a settled cell
//   new_piece   out  1        board processing finished (1 cycle)
//   score       out  SCORE_W  rows cleared, saturating
//   game_over   out  1        sticky, a piece locked into row 0
//   rd_col/rd_row in 5        renderer cell address
//   rd_cell     out  1        registered board cell, 0 when out of range
module tetris_playfield
    import tetris_pkg::*;
#(
    parameter int SCORE_W = 32
) (
    input  logic               iVGA_CLK,
    input  logic               reset,
    input  logic               start_over,
    input  logic               drop_tick,
    input  logic [9:0]         ref_x,
    input  logic [9:0]         ref_y,
    input  logic [31:0]        shape,
    output logic               stop,
    output logic               hit,
    output logic               new_piece,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    input  logic [4:0]         rd_col,
    input  logic [4:0]         rd_row,
    output logic               rd_cell
);

    state_t          state, state_next;
    logic [COLS-1:0] board     [ROWS];
    logic [COLS-1:0] lock_rows [ROWS];
    logic [9:0]      live_col, live_row, lat_col, lat_row, cur_col, cur_row;
    logic [3:0]      lat_code, cur_code;
    logic [15:0]     mask;
    logic [1:0]      anchor_off;
    logic [4:0]      scan_row, shift_row;
    logic            landed, adj, lock_top, row_full, restart;
    logic            unused_shape_hi;

    assign restart         = reset || !start_over;
    assign unused_shape_hi = ^shape[31:4];
    assign live_col        = ref_x / 10'(BLOCK_SIZE);
    assign live_row        = ref_y / 10'(BLOCK_SIZE);

    // The mover respawns as soon as stop rises, so after PLAY only the latched piece is valid.
    assign cur_col  = (state == ST_PLAY) ? live_col    : lat_col;
    assign cur_row  = (state == ST_PLAY) ? live_row    : lat_row;
    assign cur_code = (state == ST_PLAY) ? shape[3:0]  : lat_code;
    assign row_full = &board[scan_row];

    tetris_shape_rom u_shape_rom (
        .code       (cur_code),
        .mask       (mask),
        .anchor_off (anchor_off)
    );

    // Per-cell geometry of the current piece against the board.
    always_comb begin
        int cc;
        int rr;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cc        = 0;
        rr        = 0;
        landed    = 1'b0;
        adj       = 1'b0;
        lock_top  = 1'b0;
        lock_rows = '{default: '0};
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                cc = int'(cur_col) - int'(anchor_off) + c;
                rr = int'(cur_row) + r;
                if (mask[4'(r * 4 + c)]) begin
                    if (rr == ROWS - 1)
                        landed = 1'b1;
                    if (cc >= 0 && cc < COLS && rr + 1 < ROWS && board[5'(rr + 1)][5'(cc)])
                        landed = 1'b1;
                    // Board edges are the mover's business, only settled cells count.
                    if (rr < ROWS) begin
                        if (cc - 1 >= 0 && cc - 1 < COLS && board[5'(rr)][5'(cc - 1)])
                            adj = 1'b1;
                        if (cc + 1 >= 0 && cc + 1 < COLS && board[5'(rr)][5'(cc + 1)])
                            adj = 1'b1;
                    end
                    if (cc >= 0 && cc < COLS && rr < ROWS) begin
                        lock_rows[5'(rr)][5'(cc)] = 1'b1;
                        if (rr == 0)
                            lock_top = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        stop       = 1'b1;
        new_piece  = 1'b0;
        case (state)
            ST_PLAY: begin
                stop = 1'b0;
                if (drop_tick && landed && !game_over)
                    state_next = ST_LOCK;
            end
            ST_LOCK:  state_next = ST_SCAN;
            ST_SCAN: begin
                if (row_full)
                    state_next = ST_SHIFT;
                else if (scan_row == 5'd0)
                    state_next = ST_DONE;
            end
            // Back to SCAN on the same row so stacked full rows are each cleared.
            ST_SHIFT: if (shift_row <= 5'd1) state_next = ST_SCAN;
            ST_DONE: begin
                new_piece  = 1'b1;
                state_next = ST_PLAY;
            end
            default: state_next = ST_PLAY;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (restart) begin
            state     <= ST_PLAY;
            // NOTE: the board is a flop array, not RAM, so a restart can clear it in one cycle.
            board     <= '{default: '0};
            score     <= '0;
            hit       <= 1'b0;
            game_over <= 1'b0;
            rd_cell   <= 1'b0;
            lat_col   <= '0;
            lat_row   <= '0;
            lat_code  <= '0;
            scan_row  <= '0;
            shift_row <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
            state   <= state_next;
            // Only reported while the piece stays live; drops to 0 the cycle LOCK starts.
            hit     <= (state == ST_PLAY) && (state_next == ST_PLAY) && adj;
            rd_cell <= (rd_row < 5'(ROWS) && rd_col < 5'(COLS)) ? board[rd_row][rd_col] : 1'b0;
            case (state)
                ST_PLAY: begin
                    if (state_next == ST_LOCK) begin
                        lat_col  <= live_col;
                        lat_row  <= live_row;
                        lat_code <= shape[3:0];
                    end
                end
                ST_LOCK: begin
                    for (int i = 0; i < ROWS; i++)
                        board[i] <= board[i] | lock_rows[i];
                    if (lock_top)
                        game_over <= 1'b1;
                    scan_row <= 5'(ROWS - 1);
                end
                ST_SCAN: begin
                    if (row_full)
                        shift_row <= scan_row;
                    else if (scan_row != 5'd0)
                        scan_row <= scan_row - 5'd1;
                end
                ST_SHIFT: begin
                    if (shift_row != 5'd0)
                        board[shift_row] <= board[shift_row - 5'd1];
                    if (shift_row <= 5'd1) begin
                        board[0] <= '0;
                        if (score != {SCORE_W{1'b1}})
                            score <= score + 1'b1;
                    end else begin
                        shift_row <= shift_row - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_playfield.sv
// Self-checking bench for tetris_playfield: directed scenarios plus randomized play,
// compared against a row-level model of the board, score and processing latency.
module tb_tetris_playfield;
    import tetris_pkg::*;

    localparam int SCORE_W  = 32;
    localparam int MAX_WAIT = 3000;

    // Piece shapes as 4x4 masks (bit r*4+c) and anchor column, codes 0..15.
    localparam logic [15:0] TB_MASK [16] = '{
        16'h0033, 16'h000F, 16'h1111, 16'h0072, 16'h0131, 16'h0027, 16'h0232, 16'h0311,
        16'h0322, 16'h0036, 16'h0063, 16'h0231, 16'h0132, 16'h0017, 16'h0071, 16'h0033};
    localparam int TB_ANCH [16] = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0};

    logic               iVGA_CLK = 1'b0;
    logic               reset, start_over, drop_tick;
    logic [9:0]         ref_x, ref_y;
    logic [31:0]        shape;
    logic               stop, hit, new_piece, game_over, rd_cell;
    logic [SCORE_W-1:0] score;
    logic [4:0]         rd_col, rd_row;

    int checks = 0;
    int errors = 0;

    bit [COLS-1:0] mb [ROWS];
    int            m_score;
    bit            m_go;

    tetris_playfield #(.SCORE_W(SCORE_W)) dut (
        .iVGA_CLK   (iVGA_CLK),
        .reset      (reset),
        .start_over (start_over),
        .drop_tick  (drop_tick),
        .ref_x      (ref_x),
        .ref_y      (ref_y),
        .shape      (shape),
        .stop       (stop),
        .hit        (hit),
        .new_piece  (new_piece),
        .score      (score),
        .game_over  (game_over),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_cell    (rd_cell)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit cell_of(input int code, input int r, input int c);
        logic [15:0] m;
        m = TB_MASK[code];
        return m[r * 4 + c];
    endfunction

    function automatic bit occ(input int x, input int y);
        if (x < 0 || x >= COLS || y < 0 || y >= ROWS) return 1'b0;
        return mb[y][x];
    endfunction

    function automatic bit model_landed(input int code, input int col, input int row);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (cell_of(code, r, c)) begin
                    if (row + r == ROWS - 1) return 1'b1;
                    if (occ(col - TB_ANCH[code] + c, row + r + 1)) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic bit model_adj(input int code, input int col, input int row);
        int x;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (cell_of(code, r, c) && row + r < ROWS) begin
                    x = col - TB_ANCH[code] + c;
                    if (occ(x - 1, row + r) || occ(x + 1, row + r)) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic int piece_width(input int code);
        int w = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (cell_of(code, r, c) && c + 1 > w) w = c + 1;
        return w;
    endfunction

    function automatic int rest_row(input int code, input int col);
        int y = 0;
        while (!model_landed(code, col, y) && y < ROWS - 1) y++;
        return y;
    endfunction

    // Places the piece, clears full rows bottom-up and returns the cycles spent scanning/shifting.
    function automatic int model_lock(input int code, input int col, input int row);
        int x, y, s, r;
        for (int pr = 0; pr < 4; pr++)
            for (int pc = 0; pc < 4; pc++)
                if (cell_of(code, pr, pc)) begin
                    x = col - TB_ANCH[code] + pc;
                    y = row + pr;
                    if (x >= 0 && x < COLS && y >= 0 && y < ROWS) begin
                        mb[y][x] = 1'b1;
                        if (y == 0) m_go = 1'b1;
                    end
                end
        s = 0;
        r = ROWS - 1;
        while (1) begin
            if (&mb[r]) begin
                s += 1 + ((r > 0) ? r : 1);
                for (int k = r; k > 0; k--) mb[k] = mb[k - 1];
                mb[0] = '0;
                m_score++;
            end else begin
                s += 1;
                if (r == 0) break;
                r--;
            end
        end
        return s;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++) mb[r] = '0;
        m_score = 0;
        m_go    = 1'b0;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic apply_reset(input bit use_start_over);
        @(negedge iVGA_CLK);
        if (use_start_over) start_over = 1'b0;
        else                reset      = 1'b1;
        @(negedge iVGA_CLK);
        reset      = 1'b0;
        start_over = 1'b1;
        model_clear();
    endtask

    task automatic set_piece(input logic [31:0] shp, input int col, input int row);
        shape = shp;
        ref_x = 10'(col * BLOCK_SIZE);
        ref_y = 10'(row * BLOCK_SIZE);
    endtask

    task automatic drop_at(input logic [31:0] shp, input int col, input int row);
        int  code, s, k;
        bit  exp_lock, stop_ok;
        code = int'(shp[3:0]);
        @(negedge iVGA_CLK);
        set_piece(shp, col, row);
        drop_tick = 1'b1;
        exp_lock  = model_landed(code, col, row) && !m_go;
        @(negedge iVGA_CLK);
        drop_tick = 1'b0;
        check("stop_after_tick", stop, exp_lock);
        if (exp_lock) begin
            check("hit_in_lock", hit, 1'b0);
            s       = model_lock(code, col, row);
            k       = 0;
            stop_ok = 1'b1;
            while (!new_piece && k < MAX_WAIT) begin
                if (!stop) stop_ok = 1'b0;
                @(negedge iVGA_CLK);
                k++;
            end
            check("new_piece_latency", k, 1 + s);
            check("stop_held", stop_ok & stop, 1'b1);
            @(negedge iVGA_CLK);
            check("new_piece_pulse", new_piece, 1'b0);
            check("stop_released", stop, 1'b0);
        end
        check("score", score, m_score);
        check("game_over", game_over, m_go);
    endtask

    task automatic drop_natural(input logic [31:0] shp, input int col);
        drop_at(shp, col, rest_row(int'(shp[3:0]), col));
    endtask

    task automatic probe_hit(input logic [31:0] shp, input int col, input int row);
        @(negedge iVGA_CLK);
        set_piece(shp, col, row);
        drop_tick = 1'b0;
        @(negedge iVGA_CLK);
        check("hit", hit, model_adj(int'(shp[3:0]), col, row));
    endtask

    task automatic check_board(input string tag);
        logic [COLS-1:0] got;
        got = '0;
        for (int i = 0; i <= ROWS * COLS; i++) begin
            @(negedge iVGA_CLK);
            if (i > 0) begin
                got[(i - 1) % COLS] = rd_cell;
                if ((i - 1) % COLS == COLS - 1)
                    check($sformatf("%s_row%0d", tag, (i - 1) / COLS), got, mb[(i - 1) / COLS]);
            end
            if (i < ROWS * COLS) begin
                rd_row = 5'(i / COLS);
                rd_col = 5'(i % COLS);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int code, col, row, w;
        logic [31:0] shp;

        reset = 1'b1; start_over = 1'b1; drop_tick = 1'b0;
        shape = '0; ref_x = '0; ref_y = '0; rd_col = '0; rd_row = '0;
        model_clear();
        repeat (2) @(negedge iVGA_CLK);

        // Reset state.
        apply_reset(1'b0);
        check("rst_stop", stop, 1'b0);
        check("rst_hit", hit, 1'b0);
        check("rst_new_piece", new_piece, 1'b0);
        check("rst_game_over", game_over, 1'b0);
        check("rst_score", score, 0);
        check("rst_rd_cell", rd_cell, 1'b0);
        check_board("rst_board");

        // Square on the floor of an empty board.
        drop_at(32'h0, 10, 22);
        check_board("square_board");
        @(negedge iVGA_CLK); rd_row = 5'd23; rd_col = 5'd24;
        @(negedge iVGA_CLK); check("rd_col_out_of_range", rd_cell, 1'b0);
        rd_row = 5'd30; rd_col = 5'd10;
        @(negedge iVGA_CLK); check("rd_row_out_of_range", rd_cell, 1'b0);

        // Single row clear: row 23 full except cols 10-11, old row 22 drops into 23.
        apply_reset(1'b0);
        drop_at(32'h1, 1, 23);
        drop_at(32'h1, 5, 23);
        drop_at(32'h1, 13, 23);
        drop_at(32'h1, 17, 23);
        drop_at(32'h1, 21, 23);
        drop_at(32'h0, 8, 22);
        drop_at(32'h0, 10, 22);
        check("single_clear_score", score, 1);
        check_board("single_clear_board");

        // Two stacked full rows from one lock.
        apply_reset(1'b0);
        for (int c = 0; c < COLS; c += 2)
            if (c != 10) drop_at(32'h0, c, 22);
        drop_at(32'h0, 10, 22);
        check("double_clear_score", score, 2);
        check_board("double_clear_board");

        // Horizontal adjacency against a column of settled cells at col 9.
        apply_reset(1'b0);
        for (int n = 0; n < 5; n++) drop_natural(32'h2, 9);
        probe_hit(32'h0, 10, 5);
        probe_hit(32'h0, 11, 5);
        probe_hit(32'h0, 0, 0);
        probe_hit(32'h0, 22, 10);
        drop_at(32'h0, 10, 5);
        drop_natural(32'h2, 10);
        check_board("hit_board");

        // Game over then ignored drops, then start_over.
        apply_reset(1'b0);
        for (int n = 0; n < 6; n++) drop_natural(32'h2, 0);
        check("game_over_set", game_over, 1'b1);
        drop_at(32'h0, 10, 22);
        drop_at(32'h0, 12, 22);
        apply_reset(1'b1);
        check("start_over_game_over", game_over, 1'b0);
        check("start_over_score", score, 0);
        check_board("start_over_board");

        // Reset in the middle of a row shift.
        apply_reset(1'b0);
        for (int c = 0; c < COLS; c += 2)
            if (c != 10) drop_at(32'h0, c, 22);
        @(negedge iVGA_CLK);
        set_piece(32'h0, 10, 22);
        drop_tick = 1'b1;
        @(negedge iVGA_CLK);
        drop_tick = 1'b0;
        repeat (4) @(negedge iVGA_CLK);
        check("stop_mid_shift", stop, 1'b1);
        reset = 1'b1;
        @(negedge iVGA_CLK);
        reset = 1'b0;
        model_clear();
        check("abort_stop", stop, 1'b0);
        check("abort_score", score, 0);
        check("abort_new_piece", new_piece, 1'b0);
        begin
            bit seen = 1'b0;
            repeat (40) begin
                @(negedge iVGA_CLK);
                if (new_piece) seen = 1'b1;
            end
            check("abort_no_new_piece", seen, 1'b0);
        end
        check_board("abort_board");

        // Randomized play until the stack reaches the top.
        apply_reset(1'b0);
        for (int n = 0; n < 200 && !m_go; n++) begin
            shp  = $urandom();
            code = int'(shp[3:0]);
            w    = piece_width(code);
            col  = TB_ANCH[code] + int'($urandom_range(0, COLS - w));
            row  = int'($urandom_range(0, ROWS - 1));
            probe_hit(shp, col, row);
            shp  = $urandom();
            code = int'(shp[3:0]);
            w    = piece_width(code);
            col  = TB_ANCH[code] + int'($urandom_range(0, COLS - w));
            drop_natural(shp, col);
            if (n % 40 == 39) check_board("rand_board");
        end
        check_board("rand_final_board");
        drop_at(32'h0, 10, 0);
        apply_reset(1'b1);
        check_board("rand_restart_board");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
